fp_extract: RTL
===============

Name: fp_extract

Overview:
Front-end stage of the 12-bit linear-to-floating-point converter. It accepts a 12-bit two's-complement sample and converts it to sign-magnitude. A sequential leading-zero scan then produces the sign S, exponent E[2:0], significand Sig[3:0] and rounding bit F. Its outputs feed the Rounding stage directly (E, Sig, F), with S passed alongside.

Parameters:
None. The format is fixed: 12-bit input, 3-bit exponent, 4-bit significand, 1 rounding bit.

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous, active-low reset
D  input  12  two's-complement sample
in_valid  input  1  D is valid
in_ready  output  1  block can accept D (high only in IDLE)
S  output  1  sign bit
E  output  3  exponent to Rounding
Sig  output  4  significand to Rounding
F  output  1  first bit below Sig, to Rounding
out_valid  output  1  S/E/Sig/F are valid
out_ready  input  1  downstream accepts the result

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; S=0, E=0, Sig=0, F=0, out_valid=0; in_ready=1 (decoded from IDLE). Reset mid-operation discards the sample in flight immediately; there is no partial output.
- FSM states: IDLE, ABS, SCAN, DONE.
- IDLE: in_ready=1. If in_valid is high on an edge, D is captured into the data register and the FSM goes to ABS.
- in_valid in any other state is ignored; the sample is not captured.
- ABS, one cycle:
  - sign = D[11].
  - mag = sign ? -D : D, using a 12-bit two's-complement negate.
  - D=12'h800 gives mag=12'h800, which is clamped to 12'h7FF. After the clamp, mag[11]=0 always.
  - Working exponent ecnt is loaded with 7. Next state is SCAN.
- SCAN, one iteration per clock:
  - If ecnt==0 or mag[10]==1: latch S=sign, E=ecnt, Sig=mag[10:7], F=mag[6]; go to DONE.
  - Otherwise: mag <= mag<<1 (zero fill), ecnt <= ecnt-1; stay in SCAN.
  - k is the number of shifts, 0..7, equal to leading zeros in mag[10:0] capped at 7.
  - E=0 case (no 1 in mag[10:4]): Sig = original mag[3:0], F=0.
- DONE: out_valid=1. S/E/Sig/F hold stable while out_valid && !out_ready.
  - On an edge with out_ready=1, out_valid drops and the FSM returns to IDLE.
  - A new sample cannot be accepted in that same cycle; the earliest accept is the following edge.
- Latency: with accept on edge n, out_valid is high after edge n+2+k. The minimum is 2 cycles (k=0) and the maximum is 9 (k=7).
- Throughput: one sample per k+4 cycles when out_ready is held high.
- All outputs are registered; none are combinational from D.
- The Rounding stage handles any Sig overflow. This block never rounds.

Test Plan:
- Reset, then D=12'h000 and in_valid pulse -> out_valid after edge n+9; S=0, E=3'd0, Sig=4'b0000, F=0.
- D=12'd422 (0001_1010_0110) -> k=2, out_valid after edge n+4; S=0, E=3'd5, Sig=4'b1101, F=0.
- D=12'h800 (-2048) -> clamped to 2047, k=0, out_valid after edge n+2; S=1, E=3'd7, Sig=4'b1111, F=1.
- D=12'hFFF (-1) -> S=1, E=3'd0, Sig=4'b0001, F=0. Also D=12'd46 -> S=0, E=3'd2, Sig=4'b1011, F=1.
- Backpressure: complete a conversion with out_ready=0 for 5 cycles while in_valid=1 with D=12'h123.
  - Outputs stay constant, in_ready=0, and the new D is not captured.
  - Then raise out_ready: one-cycle handshake, return to IDLE, next D accepted on the following edge.
- Drive rst_n low mid-SCAN, asynchronously between clock edges -> out_valid=0, S/E/Sig/F=0 and in_ready=1 immediately. After release, a fresh D=12'd422 converts correctly.

Source files
------------

// File: rtl/fp_extract.sv
// rtl/fp_extract.sv - front end of the 12-bit linear-to-float converter
// Converts a two's-complement sample to sign-magnitude, then scans for the leading one.
module fp_extract (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] D,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        S,
    output logic [2:0]  E,
    output logic [3:0]  Sig,
    output logic        F,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ABS  = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic [11:0] data_q;
    logic [11:0] mag_q;
    logic        sign_q;
    logic [2:0]  ecnt_q;
    logic [11:0] neg_val;
    logic [11:0] abs_val;
    logic        scan_end;

    // -2048 has no positive twin in 12 bits, so it saturates to the largest magnitude
    always_comb begin
        neg_val = ~data_q + 12'd1;
        abs_val = data_q[11] ? neg_val : data_q;
        if (abs_val == 12'h800) begin
            abs_val = 12'h7FF;
        end
    end

    assign scan_end = (ecnt_q == 3'd0) || mag_q[10];
    assign in_ready = (state == IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = ABS;
            ABS:  state_nx = SCAN;
            SCAN: if (scan_end) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= 12'd0;
            mag_q     <= 12'd0;
            sign_q    <= 1'b0;
            ecnt_q    <= 3'd0;
            S         <= 1'b0;
            E         <= 3'd0;
            Sig       <= 4'd0;
            F         <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= D;
                    end
                end
                ABS: begin
                    sign_q <= data_q[11];
                    mag_q  <= abs_val;
                    ecnt_q <= 3'd7;
                end
                SCAN: begin
                    if (scan_end) begin
                        S         <= sign_q;
                        E         <= ecnt_q;
                        Sig       <= mag_q[10:7];
                        F         <= mag_q[6];
                        out_valid <= 1'b1;
                    end else begin
                        mag_q  <= {mag_q[10:0], 1'b0};
                        ecnt_q <= ecnt_q - 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
